mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers, serving the multicycle CPU's MULT, MULTU, DIV, DIVU, MTHI and MTLO instructions. The CPU issues one operation with a start pulse, stalls on `busy`, and reads HI/LO directly for MFHI/MFLO. Operand width is parametrised; one result bit is produced per cycle. A flush input cancels an in-flight operation on an exception.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be ≥ 4.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  issue request; sampled only in IDLE.
- `op`  in  3  operation code (package constants).
- `a`  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `flush`  in  1  cancel in-flight operation.
- `busy`  out  1  operation in progress; CPU stalls MD instructions and MFHI/MFLO while high.
- `done`  out  1  one-cycle pulse: HI/LO hold the new result.
- `div_by_zero`  out  1  valid with `done`; high for DIV/DIVU with `b == 0`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start` high, `flush` low:
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes (signed ops take absolute values; unsigned ops pass through), record result signs, set counter to WIDTH-1, go to CALC.
  - MTHI/MTLO: write `a` to HI/LO at that edge; stay in IDLE; no `busy`, no `done`.
  - Codes 6, 7: ignored.
- CALC, multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
- CALC runs WIDTH cycles, then goes to FIX.
- FIX: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
  - Multiply: negate the 2·WIDTH product when the operand signs differ. HI = upper half, LO = lower half.
  - Divide: LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - Signed MIN / −1: LO = MIN, HI = 0 (falls out of magnitude arithmetic).
  - Divide by zero, signed or unsigned: LO = all ones, HI = `a` as issued; `div_by_zero` = 1.
- `start` while `busy`: ignored; no queuing.
- `flush` in CALC or FIX: return to IDLE at the next edge; HI/LO unchanged; no `done`.
- `flush` and `start` together in IDLE: `flush` wins; nothing issued.
- `rst`, any time including mid-operation: state IDLE; `hi`, `lo`, `busy`, `done`, `div_by_zero` all 0.

## Timing
- Edge E0 samples `start`.
- `busy` is high from after E0 through the FIX cycle.
- CALC iterations complete at edges E1..E(WIDTH).
- FIX completes at E(WIDTH+1). HI/LO update there, `done` goes high, `busy` goes low. Latency is WIDTH+1 cycles (33 at WIDTH=32).
- A new `start` may be presented in the cycle where `done` is high.
- MTHI/MTLO: HI/LO valid one edge after sampling.
- All outputs come directly from registers; no combinational paths from inputs.
- Counter width: `$clog2(WIDTH)`.

## Structure
- Package `md_pkg`:
  - op constants: `MD_MULT`=0, `MD_MULTU`=1, `MD_DIV`=2, `MD_DIVU`=3, `MD_MTHI`=4, `MD_MTLO`=5.
  - state encoding: IDLE / CALC / FIX.
  - a WIDTH-generic two's-complement negate/absolute-value function.
- Single module. No sub-module: the multiply and divide datapaths share the accumulator and counter.

## Test plan
- WIDTH=32, MULT a=0xFFFFFFFD (−3), b=7 → `done` 33 cycles after E0; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=7, b=2 → LO=3, HI=1.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0, `div_by_zero`=0.
- DIVU a=5, b=0 → LO=0xFFFFFFFF, HI=5, `div_by_zero`=1 with `done`.
- Flush and busy:
  - HI/LO preloaded 0x11/0x22 via MTHI/MTLO.
  - DIV issued, `flush` at cycle 10 → `busy` low next cycle, HI=0x11, LO=0x22, no `done`.
  - `start` pulsed mid-operation → ignored; only one `done` occurs.
- MTHI a=0x12345678 → HI=0x12345678 after one edge, `busy` never high.
- `rst` asserted at cycle 5 of a MULT → all outputs 0 immediately; the next MULT completes normally.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// md_pkg: shared op codes, FSM states and sign helpers
// for the iterative multiply/divide unit.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } md_state_t;

  // Widest value the helper handles; callers zero-extend
  // into it and truncate back. Low bits of a two's-complement
  // negate do not depend on the extension, so any WIDTH
  // with 2*WIDTH <= MD_MAXW is exact.
  localparam int MD_MAXW = 128;
  typedef logic [MD_MAXW-1:0] md_wide_t;

  // Conditional two's-complement negate; abs(x) = md_neg(x, sign).
  function automatic md_wide_t md_neg(input md_wide_t x,
                                      input logic en);
    return en ? (~x + md_wide_t'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: CPU <-> multiply/divide unit bundle.
// master = CPU side, slave = unit side.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: one-bit-per-cycle multiply/divide with
// architectural HI/LO; shared accumulator for both ops.
import md_pkg::*;

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  s
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  md_state_t        r_state, w_next;
  logic [W2-1:0]    r_acc, w_acc;
  logic [WIDTH-1:0] r_opb, w_opb;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic             r_div, w_div;
  logic             r_negq, w_negq;
  logic             r_negr, w_negr;
  logic             r_dz, w_dz;
  logic [WIDTH-1:0] r_hi, w_hi;
  logic [WIDTH-1:0] r_lo, w_lo;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_dzo, w_dzo;

  logic             w_issue, w_arith, w_sgn;
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;
  logic [WIDTH:0]   w_sum, w_trial;
  logic [W2-1:0]    w_mstep, w_dstep, w_prod;
  logic [WIDTH-1:0] w_quo, w_rem;

  assign w_issue = (r_state == ST_IDLE) && s.start && !s.flush;
  assign w_arith = (s.op <= MD_DIVU);
  assign w_sgn   = (s.op == MD_MULT) || (s.op == MD_DIV);
  assign w_sa    = w_sgn & s.a[WIDTH-1];
  assign w_sb    = w_sgn & s.b[WIDTH-1];
  assign w_a_abs = WIDTH'(md_neg(MD_MAXW'(s.a), w_sa));
  assign w_b_abs = WIDTH'(md_neg(MD_MAXW'(s.b), w_sb));

  // Multiply: acc = {partial, multiplier}, add then shift right.
  assign w_sum   = {1'b0, r_acc[W2-1:WIDTH]}
                 + {1'b0, (r_acc[0] ? r_opb : '0)};
  assign w_mstep = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, restoring step.
  assign w_trial = r_acc[W2-1:WIDTH-1] - {1'b0, r_opb};
  assign w_dstep = w_trial[WIDTH]
                 ? {r_acc[W2-2:0], 1'b0}
                 : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign fix-up. With b == 0 the remainder ends up as |a|,
  // so HI = a falls out; only LO needs forcing.
  assign w_prod = W2'(md_neg(MD_MAXW'(r_acc), r_negq));
  assign w_quo  = WIDTH'(md_neg(MD_MAXW'(r_acc[WIDTH-1:0]), r_negq));
  assign w_rem  = WIDTH'(md_neg(MD_MAXW'(r_acc[W2-1:WIDTH]), r_negr));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_issue && w_arith) w_next = ST_CALC;
      ST_CALC: begin
        if (s.flush)           w_next = ST_IDLE;
        else if (r_cnt == '0)  w_next = ST_FIX;
      end
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    w_acc  = r_acc;
    w_opb  = r_opb;
    w_cnt  = r_cnt;
    w_div  = r_div;
    w_negq = r_negq;
    w_negr = r_negr;
    w_dz   = r_dz;
    w_hi   = r_hi;
    w_lo   = r_lo;
    w_done = 1'b0;
    w_dzo  = 1'b0;
    w_busy = (w_next != ST_IDLE);
    unique case (r_state)
      ST_IDLE: begin
        if (w_issue && w_arith) begin
          w_div  = s.op[1];
          w_negq = w_sa ^ w_sb;
          w_negr = w_sa;
          w_dz   = s.op[1] && (s.b == '0);
          w_cnt  = CW'(WIDTH - 1);
          w_acc  = s.op[1] ? {{WIDTH{1'b0}}, w_a_abs}
                           : {{WIDTH{1'b0}}, w_b_abs};
          w_opb  = s.op[1] ? w_b_abs : w_a_abs;
        end else if (w_issue && s.op == MD_MTHI) begin
          w_hi = s.a;
        end else if (w_issue && s.op == MD_MTLO) begin
          w_lo = s.a;
        end
      end
      ST_CALC: begin
        if (!s.flush) begin
          w_acc = r_div ? w_dstep : w_mstep;
          w_cnt = r_cnt - CW'(1);
        end
      end
      ST_FIX: begin
        if (!s.flush) begin
          w_done = 1'b1;
          w_dzo  = r_dz;
          if (r_div) begin
            w_hi = w_rem;
            w_lo = r_dz ? '1 : w_quo;
          end else begin
            w_hi = w_prod[W2-1:WIDTH];
            w_lo = w_prod[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_opb  <= '0;
      r_cnt  <= '0;
      r_div  <= 1'b0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_dz   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dzo  <= 1'b0;
    end else begin
      r_acc  <= w_acc;
      r_opb  <= w_opb;
      r_cnt  <= w_cnt;
      r_div  <= w_div;
      r_negq <= w_negq;
      r_negr <= w_negr;
      r_dz   <= w_dz;
      r_hi   <= w_hi;
      r_lo   <= w_lo;
      r_busy <= w_busy;
      r_done <= w_done;
      r_dzo  <= w_dzo;
    end
  end

  assign s.busy        = r_busy;
  assign s.done        = r_done;
  assign s.div_by_zero = r_dzo;
  assign s.hi          = r_hi;
  assign s.lo          = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed + random checks of mul_div_unit
// against an arithmetic reference model.
module tb_mul_div_unit;
  import md_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) mif();
  mul_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .s   (mif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] hi,
                                output logic [31:0] lo,
                                output logic dz);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT: begin
        p = sa * sb;
        hi = p[63:32]; lo = p[31:0];
      end
      MD_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        hi = p[63:32]; lo = p[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b == 0) begin
          dz = 1'b1; lo = '1; hi = a;
        end else if (op == MD_DIV) begin
          p = sa / sb; lo = p[31:0];
          p = sa % sb; hi = p[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    mif.start = 1'b1;
    mif.op = op;
    mif.a = a;
    mif.b = b;
    step();
    mif.start = 1'b0;
  endtask

  // Issue one op, wait (bounded) for done, check everything.
  task automatic run_op(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eh, el;
    logic ed;
    int n;
    logic busy_ok;
    model(op, a, b, eh, el, ed);
    issue(op, a, b);
    n = 0;
    busy_ok = 1'b1;
    while (!mif.done && n < 60) begin
      busy_ok &= mif.busy;
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(W + 1));
    chk({tag, "_busy"}, {63'b0, busy_ok}, 64'd1);
    chk({tag, "_hi"}, {32'b0, mif.hi}, {32'b0, eh});
    chk({tag, "_lo"}, {32'b0, mif.lo}, {32'b0, el});
    chk({tag, "_dz"}, {63'b0, mif.div_by_zero}, {63'b0, ed});
    chk({tag, "_idle"}, {63'b0, mif.busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] eh, el;
    logic ed;
    int nd;
    logic [31:0] ch, cl;

    mif.start = 1'b0;
    mif.flush = 1'b0;
    mif.op = '0;
    mif.a = '0;
    mif.b = '0;
    rst = 1'b1;
    step();
    step();
    chk("rst_hi", {32'b0, mif.hi}, 64'd0);
    chk("rst_lo", {32'b0, mif.lo}, 64'd0);
    chk("rst_flags",
        {61'b0, mif.busy, mif.done, mif.div_by_zero}, 64'd0);
    rst = 1'b0;
    step();

    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7);
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_7_2", MD_DIVU, 32'd7, 32'd2);
    run_op("div_min", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_z", MD_DIVU, 32'd5, 32'd0);
    run_op("div_zneg", MD_DIV, 32'hFFFF_FF00, 32'd0);
    run_op("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000);

    // Random ops, issued back-to-back in the done cycle.
    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rnd%0d", i),
             3'($urandom_range(0, 3)), pick(), pick());
    end

    // MTHI / MTLO and an ignored code.
    issue(MD_MTHI, 32'h1234_5678, 32'h0);
    chk("mthi_hi", {32'b0, mif.hi}, 64'h1234_5678);
    chk("mthi_busy", {63'b0, mif.busy}, 64'd0);
    step();
    chk("mthi_flags", {62'b0, mif.busy, mif.done}, 64'd0);
    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    step();
    chk("op6_hi", {32'b0, mif.hi}, 64'h1234_5678);
    chk("op6_busy", {63'b0, mif.busy}, 64'd0);

    // Flush mid-divide leaves HI/LO alone.
    issue(MD_MTHI, 32'h11, 32'h0);
    issue(MD_MTLO, 32'h22, 32'h0);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 9; i++) step();
    mif.flush = 1'b1;
    step();
    mif.flush = 1'b0;
    chk("fl_busy", {63'b0, mif.busy}, 64'd0);
    chk("fl_hi", {32'b0, mif.hi}, 64'h11);
    chk("fl_lo", {32'b0, mif.lo}, 64'h22);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      nd += int'(mif.done);
      step();
    end
    chk("fl_nodone", 64'(nd), 64'd0);

    // flush wins over start in IDLE.
    mif.flush = 1'b1;
    issue(MD_MTHI, 32'h99, 32'h0);
    mif.flush = 1'b0;
    step();
    chk("flst_hi", {32'b0, mif.hi}, 64'h11);

    // start while busy is ignored.
    model(MD_MULTU, 32'h0001_0003, 32'h0002_0005, eh, el, ed);
    issue(MD_MULTU, 32'h0001_0003, 32'h0002_0005);
    for (int i = 0; i < 4; i++) step();
    issue(MD_MTLO, 32'hDEAD, 32'h0);
    nd = 0;
    ch = '0;
    cl = '0;
    for (int i = 0; i < 70; i++) begin
      if (mif.done) begin
        nd++;
        ch = mif.hi;
        cl = mif.lo;
      end
      step();
    end
    chk("sb_ndone", 64'(nd), 64'd1);
    chk("sb_hi", {32'b0, ch}, {32'b0, eh});
    chk("sb_lo", {32'b0, cl}, {32'b0, el});

    // Asynchronous reset in the middle of a multiply.
    issue(MD_MULT, 32'h0000_1234, 32'hFFFF_0001);
    for (int i = 0; i < 4; i++) step();
    #2;
    rst = 1'b1;
    #1;
    chk("mr_hi", {32'b0, mif.hi}, 64'd0);
    chk("mr_lo", {32'b0, mif.lo}, 64'd0);
    chk("mr_flags",
        {61'b0, mif.busy, mif.done, mif.div_by_zero}, 64'd0);
    step();
    rst = 1'b0;
    step();
    run_op("post_rst", MD_MULT, 32'h0000_1234, 32'hFFFF_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
